// File: rtl/core_test_controller.sv
// Run controller for the RV32I core under test: sequences core reset, snoops tohost stores, enforces a cycle budget.
// Optional store counter enabled by defining CORE_TEST_CTRL_STORE_CNT_EN.
module core_test_controller #(
  parameter int unsigned RST_CYCLES     = 2,
  parameter int unsigned TIMEOUT_CYCLES = 100,
  parameter logic [31:0] TOHOST_ADDR    = 32'h0000_1000,
  parameter int unsigned CNT_W          = 32
) (
  input  logic             i_clk,
  input  logic             i_rstn,
  input  logic             i_start,
  input  logic             i_mem_we,
  input  logic [31:0]      i_mem_addr,
  input  logic [31:0]      i_mem_wdata,
  output logic             o_core_rstn,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_pass,
  output logic             o_fail,
  output logic             o_timeout,
  output logic [30:0]      o_code,
  output logic [CNT_W-1:0] o_cycles,
  output logic [CNT_W-1:0] o_stores
);

  typedef enum logic [1:0] {IDLE, RESET, RUN, DONE} state_t;

  localparam logic [31:0]      RST_LOAD = 32'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t      state, state_nxt;
  logic [31:0] rst_cnt;
  logic        term, is_pass, tmo_hit, restart;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    sat_inc = (&v) ? v : v + CNT_ONE;
  endfunction

  assign term    = i_mem_we && (i_mem_addr == TOHOST_ADDR) && i_mem_wdata[0];
  assign is_pass = (i_mem_wdata == 32'h1);
  assign tmo_hit = (TIMEOUT_CYCLES != 0) && (o_cycles == TMO_LAST);
  assign restart = i_start && ((state == IDLE) || (state == DONE));

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE: if (i_start) state_nxt = RESET;
      RESET:      if (rst_cnt == 32'd0) state_nxt = RUN;
      RUN:        if (term || tmo_hit) state_nxt = DONE;
      default:    state_nxt = IDLE;
    endcase
  end

  // state register and registered status; a terminating store takes priority over timeout
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state       <= IDLE;
      rst_cnt     <= '0;
      o_core_rstn <= 1'b0;
      o_busy      <= 1'b0;
      o_done      <= 1'b0;
      o_pass      <= 1'b0;
      o_fail      <= 1'b0;
      o_timeout   <= 1'b0;
      o_code      <= '0;
      o_cycles    <= '0;
    end else begin
      state       <= state_nxt;
      o_core_rstn <= (state_nxt == RUN);
      o_busy      <= (state_nxt == RESET) || (state_nxt == RUN);
      o_done      <= (state_nxt == DONE);
      case (state)
        IDLE, DONE: begin
          if (i_start) begin
            rst_cnt   <= RST_LOAD;
            o_pass    <= 1'b0;
            o_fail    <= 1'b0;
            o_timeout <= 1'b0;
            o_code    <= '0;
            o_cycles  <= '0;
          end
        end
        RESET: begin
          if (rst_cnt != 32'd0) rst_cnt <= rst_cnt - 32'd1;
        end
        RUN: begin
          o_cycles <= sat_inc(o_cycles);
          if (term) begin
            if (is_pass) begin
              o_pass <= 1'b1;
            end else begin
              o_fail <= 1'b1;
              o_code <= i_mem_wdata[31:1];
            end
          end else if (tmo_hit) begin
            o_timeout <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef CORE_TEST_CTRL_STORE_CNT_EN
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      o_stores <= '0;
    end else if (restart) begin
      o_stores <= '0;
    end else if ((state == RUN) && i_mem_we) begin
      o_stores <= sat_inc(o_stores);
    end
  end
`else
  assign o_stores = '0;
`endif

endmodule

// File: tb/tb_core_test_controller.sv
// Directed bench for core_test_controller: a default-parameter instance and a RST_CYCLES=5 / no-timeout instance.
module tb_core_test_controller;

  localparam logic [31:0] TOHOST = 32'h0000_1000;
`ifdef CORE_TEST_CTRL_STORE_CNT_EN
  localparam int STORE_EN = 1;
`else
  localparam int STORE_EN = 0;
`endif

  logic        clk = 1'b0;
  logic        rst_n, start, start2, we, we2;
  logic [31:0] addr, wdata;

  logic        core_rstn, busy, done, pass, fail, tmo;
  logic [30:0] code;
  logic [31:0] cycles, stores;
  logic        core_rstn2, busy2, done2, pass2, fail2, tmo2;
  logic [30:0] code2;
  logic [31:0] cycles2, stores2;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  core_test_controller dut (
    .i_clk(clk), .i_rstn(rst_n), .i_start(start), .i_mem_we(we),
    .i_mem_addr(addr), .i_mem_wdata(wdata),
    .o_core_rstn(core_rstn), .o_busy(busy), .o_done(done), .o_pass(pass),
    .o_fail(fail), .o_timeout(tmo), .o_code(code), .o_cycles(cycles), .o_stores(stores)
  );

  core_test_controller #(.RST_CYCLES(5), .TIMEOUT_CYCLES(0)) dut2 (
    .i_clk(clk), .i_rstn(rst_n), .i_start(start2), .i_mem_we(we2),
    .i_mem_addr(addr), .i_mem_wdata(wdata),
    .o_core_rstn(core_rstn2), .o_busy(busy2), .o_done(done2), .o_pass(pass2),
    .o_fail(fail2), .o_timeout(tmo2), .o_code(code2), .o_cycles(cycles2), .o_stores(stores2)
  );

  // pulse start for one edge; returns at the negedge after the sampling edge
  task automatic pulse_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d);
    we = 1'b1; addr = a; wdata = d;
    @(negedge clk);
    we = 1'b0; addr = '0; wdata = '0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 0; start2 = 0; we = 0; we2 = 0; addr = '0; wdata = '0;
    #12;
    n_checks++;
    if ({core_rstn, busy, done, pass, fail, tmo} !== 6'b0) begin
      n_fail++; $display("FAIL reset_flags: got %b expected 000000", {core_rstn, busy, done, pass, fail, tmo});
    end
    n_checks++;
    if ({code, cycles, stores} !== 95'b0) begin
      n_fail++; $display("FAIL reset_counters: code=%0h cycles=%0d stores=%0d expected 0", code, cycles, stores);
    end
    @(negedge clk) rst_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({busy, done, core_rstn} !== 3'b000) begin
      n_fail++; $display("FAIL reset_idle: busy/done/core_rstn=%b expected 000", {busy, done, core_rstn});
    end
  endtask

  task automatic test_pass();
    pulse_start();
    n_checks++;
    if ({busy, core_rstn, done} !== 3'b100) begin
      n_fail++; $display("FAIL start_busy: busy/core_rstn/done=%b expected 100", {busy, core_rstn, done});
    end
    @(negedge clk);
    n_checks++;
    if (core_rstn !== 1'b0) begin
      n_fail++; $display("FAIL rst_hold: core_rstn=%b expected 0", core_rstn);
    end
    @(negedge clk);
    n_checks++;
    if ({core_rstn, cycles} !== {1'b1, 32'd0}) begin
      n_fail++; $display("FAIL run_entry: core_rstn=%b cycles=%0d expected 1 0", core_rstn, cycles);
    end
    repeat (20) @(negedge clk);
    n_checks++;
    if (cycles !== 32'd20) begin
      n_fail++; $display("FAIL run_count: cycles=%0d expected 20", cycles);
    end
    store(TOHOST, 32'h1);
    n_checks++;
    if ({done, pass, fail, tmo, core_rstn, busy} !== 6'b110000) begin
      n_fail++; $display("FAIL pass_flags: done/pass/fail/tmo/rstn/busy=%b expected 110000", {done, pass, fail, tmo, core_rstn, busy});
    end
    n_checks++;
    if (cycles !== 32'd21) begin
      n_fail++; $display("FAIL pass_cycles: cycles=%0d expected 21", cycles);
    end
    n_checks++;
    if (stores !== 32'(STORE_EN)) begin
      n_fail++; $display("FAIL pass_stores: stores=%0d expected %0d", stores, STORE_EN);
    end
    repeat (3) @(negedge clk);
    n_checks++;
    if ({done, pass, cycles} !== {2'b11, 32'd21}) begin
      n_fail++; $display("FAIL done_frozen: done=%b pass=%b cycles=%0d expected 1 1 21", done, pass, cycles);
    end
  endtask

  task automatic test_fail();
    pulse_start();
    n_checks++;
    if ({pass, done, cycles, stores} !== 66'b0) begin
      n_fail++; $display("FAIL restart_clear: pass=%b done=%b cycles=%0d stores=%0d expected all 0", pass, done, cycles, stores);
    end
    repeat (2) @(negedge clk);
    repeat (5) @(negedge clk);
    store(TOHOST, 32'h0000_0007);
    n_checks++;
    if ({done, pass, fail, tmo} !== 4'b1010) begin
      n_fail++; $display("FAIL fail_flags: done/pass/fail/tmo=%b expected 1010", {done, pass, fail, tmo});
    end
    n_checks++;
    if ({code, cycles} !== {31'd3, 32'd6}) begin
      n_fail++; $display("FAIL fail_code: code=%0d cycles=%0d expected 3 6", code, cycles);
    end
  endtask

  task automatic test_ignored();
    pulse_start();
    repeat (2) @(negedge clk);
    repeat (3) @(negedge clk);
    store(TOHOST, 32'h2);
    store(TOHOST + 32'd4, 32'h1);
    n_checks++;
    if ({done, busy, pass, fail, cycles} !== {4'b0100, 32'd5}) begin
      n_fail++; $display("FAIL ignored_store: done/busy/pass/fail=%b cycles=%0d expected 0100 5", {done, busy, pass, fail}, cycles);
    end
    store(TOHOST, 32'h5);
    n_checks++;
    if ({done, fail, code, stores} !== {2'b11, 31'd2, 32'(3 * STORE_EN)}) begin
      n_fail++; $display("FAIL ignored_then_term: done=%b fail=%b code=%0d stores=%0d expected 1 1 2 %0d", done, fail, code, stores, 3 * STORE_EN);
    end
  endtask

  task automatic test_store_count();
    pulse_start();
    repeat (2) @(negedge clk);
    store(32'h0000_2000, 32'h1);
    store(32'h0000_2004, 32'hFFFF_FFFF);
    store(32'h0000_0FFC, 32'h1);
    @(negedge clk);
    store(TOHOST, 32'h1);
    n_checks++;
    if ({done, pass, cycles, stores} !== {2'b11, 32'd5, 32'(4 * STORE_EN)}) begin
      n_fail++; $display("FAIL store_count: done=%b pass=%b cycles=%0d stores=%0d expected 1 1 5 %0d", done, pass, cycles, stores, 4 * STORE_EN);
    end
  endtask

  task automatic test_timeout();
    pulse_start();
    repeat (2) @(negedge clk);
    repeat (99) @(negedge clk);
    n_checks++;
    if ({done, cycles} !== {1'b0, 32'd99}) begin
      n_fail++; $display("FAIL pre_timeout: done=%b cycles=%0d expected 0 99", done, cycles);
    end
    @(negedge clk);
    n_checks++;
    if ({done, tmo, pass, fail, core_rstn, cycles} !== {5'b11000, 32'd100}) begin
      n_fail++; $display("FAIL timeout: done/tmo/pass/fail/rstn=%b cycles=%0d expected 11000 100", {done, tmo, pass, fail, core_rstn}, cycles);
    end
  endtask

  task automatic test_store_at_timeout();
    pulse_start();
    repeat (2) @(negedge clk);
    repeat (99) @(negedge clk);
    store(TOHOST, 32'h1);
    n_checks++;
    if ({done, pass, tmo, cycles} !== {3'b110, 32'd100}) begin
      n_fail++; $display("FAIL store_wins: done/pass/tmo=%b cycles=%0d expected 110 100", {done, pass, tmo}, cycles);
    end
  endtask

  task automatic test_no_timeout();
    int lows;
    @(negedge clk) start2 = 1'b1;
    @(negedge clk) start2 = 1'b0;
    lows = (core_rstn2 === 1'b0 && busy2 === 1'b1) ? 1 : 0;
    for (int i = 1; i < 5; i++) begin
      @(negedge clk);
      if (core_rstn2 === 1'b0) lows++;
    end
    n_checks++;
    if (lows !== 5) begin
      n_fail++; $display("FAIL rst5_low: low cycles=%0d expected 5", lows);
    end
    @(negedge clk);
    n_checks++;
    if ({core_rstn2, cycles2} !== {1'b1, 32'd0}) begin
      n_fail++; $display("FAIL rst5_rise: core_rstn=%b cycles=%0d expected 1 0", core_rstn2, cycles2);
    end
    repeat (500) @(negedge clk);
    n_checks++;
    if ({done2, busy2, tmo2, core_rstn2, cycles2} !== {4'b0101, 32'd500}) begin
      n_fail++; $display("FAIL no_timeout: done/busy/tmo/rstn=%b cycles=%0d expected 0101 500", {done2, busy2, tmo2, core_rstn2}, cycles2);
    end
  endtask

  task automatic test_async_reset();
    pulse_start();
    repeat (2) @(negedge clk);
    repeat (10) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({core_rstn, busy, done, pass, fail, tmo, code, cycles, stores} !== 101'b0) begin
      n_fail++; $display("FAIL async_reset: rstn/busy/done=%b cycles=%0d stores=%0d expected all 0", {core_rstn, busy, done}, cycles, stores);
    end
    n_checks++;
    if ({busy2, core_rstn2, cycles2} !== 34'b0) begin
      n_fail++; $display("FAIL async_reset2: busy/rstn=%b cycles=%0d expected 00 0", {busy2, core_rstn2}, cycles2);
    end
    @(negedge clk) rst_n = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({busy, done, core_rstn, cycles} !== 35'b0) begin
      n_fail++; $display("FAIL post_reset_idle: busy/done/rstn=%b cycles=%0d expected 000 0", {busy, done, core_rstn}, cycles);
    end
  endtask

  initial begin
    test_reset();
    test_pass();
    test_fail();
    test_ignored();
    test_store_count();
    test_timeout();
    test_store_at_timeout();
    test_no_timeout();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
